// File: rtl/usram_arbiter.sv
// usram_arbiter: two-requester arbiter (SoC bridge and accelerator datapath)
// in front of the single-port unified SRAM. The accelerator has priority while
// it is running, with a bounded-wait guard that forces a single SoC grant after
// MAX_WAIT consecutive stalled cycles; otherwise ties are resolved round-robin.
// Read data is steered back to the requester that issued the read, and cycles
// with both requests asserted are counted for debug.
//
// Handshake: a requester raises req with we/addr/wdata and holds them stable
// until it samples gnt = 1 in the same cycle; a req/gnt cycle is one accepted
// access. Read data returns exactly one cycle later with rvalid = 1 on the
// issuing port. There is no backpressure on the return path. A requester may
// withdraw req without having been granted.
module usram_arbiter #(
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_busy,
    // SoC side
    input  logic              soc_req,
    input  logic              soc_we,
    input  logic [ADDR_W-1:0] soc_addr,
    input  logic [WIDTH-1:0]  soc_wdata,
    output logic              soc_gnt,
    output logic              soc_rvalid,
    output logic [WIDTH-1:0]  soc_rdata,
    // accelerator side
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [WIDTH-1:0]  acc_wdata,
    output logic              acc_gnt,
    output logic              acc_rvalid,
    output logic [WIDTH-1:0]  acc_rdata,
    // SRAM side
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [WIDTH-1:0]  sram_wdata,
    input  logic [WIDTH-1:0]  sram_rdata,
    // debug
    output logic [15:0]       conflict_cnt
);

    localparam logic [7:0]  MAX_WAIT_C = 8'(MAX_WAIT);
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    // registered arbitration state
    logic              last_gnt;      // 0 = SoC won last, 1 = accelerator won last
    logic [7:0]        wait_cnt;      // consecutive SoC stall cycles while acc_busy
    logic              rd_owner_soc;  // SoC read issued last cycle
    logic              rd_owner_acc;  // accelerator read issued last cycle
    logic [15:0]       conflict_q;
    logic [ADDR_W-1:0] addr_q;        // last driven SRAM address
    logic [WIDTH-1:0]  wdata_q;       // last driven SRAM write data

    // combinational decision
    logic              soc_win;
    logic              acc_win;
    logic              any_win;
    logic              both_req;
    logic              soc_stall;

    assign both_req  = soc_req & acc_req;
    assign any_win   = soc_win | acc_win;
    assign soc_stall = soc_req & ~soc_win & acc_busy;

    // Pick at most one winner; nothing is granted while reset is held.
    always_comb begin
        soc_win = 1'b0;
        acc_win = 1'b0;
        if (!rst) begin
            if (soc_req && !acc_req) begin
                soc_win = 1'b1;
            end else if (acc_req && !soc_req) begin
                acc_win = 1'b1;
            end else if (both_req) begin
                if (acc_busy) begin
                    // accelerator priority, except one forced SoC slot
                    if (wait_cnt == MAX_WAIT_C) begin
                        soc_win = 1'b1;
                    end else begin
                        acc_win = 1'b1;
                    end
                end else begin
                    // round-robin: the side that did not win last time goes
                    if (last_gnt) begin
                        soc_win = 1'b1;
                    end else begin
                        acc_win = 1'b1;
                    end
                end
            end
        end
    end

    // Arbitration history, starvation counter and read-return tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt     <= 1'b1;
            wait_cnt     <= 8'd0;
            rd_owner_soc <= 1'b0;
            rd_owner_acc <= 1'b0;
        end else begin
            if (soc_win) begin
                last_gnt <= 1'b0;
            end else if (acc_win) begin
                last_gnt <= 1'b1;
            end

            // counts only genuine stalls under accelerator priority
            if (soc_stall) begin
                if (wait_cnt != MAX_WAIT_C) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end else begin
                wait_cnt <= 8'd0;
            end

            rd_owner_soc <= soc_win & ~soc_we;
            rd_owner_acc <= acc_win & ~acc_we;
        end
    end

    // Saturating count of cycles where both sides requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 16'd0;
        end else if (both_req && conflict_q != CNT_MAX) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    // Remember the last driven address/data so the SRAM bus is quiet when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (soc_win) begin
            addr_q  <= soc_addr;
            wdata_q <= soc_wdata;
        end else if (acc_win) begin
            addr_q  <= acc_addr;
            wdata_q <= acc_wdata;
        end
    end

    // SRAM command mux and per-port return steering; everything reads 0 in reset.
    always_comb begin
        soc_gnt      = soc_win;
        acc_gnt      = acc_win;
        sram_en      = any_win;
        sram_we      = 1'b0;
        sram_addr    = addr_q;
        sram_wdata   = wdata_q;
        soc_rvalid   = 1'b0;
        acc_rvalid   = 1'b0;
        soc_rdata    = '0;
        acc_rdata    = '0;
        conflict_cnt = 16'd0;
        if (soc_win) begin
            sram_we    = soc_we;
            sram_addr  = soc_addr;
            sram_wdata = soc_wdata;
        end else if (acc_win) begin
            sram_we    = acc_we;
            sram_addr  = acc_addr;
            sram_wdata = acc_wdata;
        end
        if (rst) begin
            sram_addr  = '0;
            sram_wdata = '0;
        end else begin
            soc_rvalid   = rd_owner_soc;
            acc_rvalid   = rd_owner_acc;
            conflict_cnt = conflict_q;
            if (rd_owner_soc) begin
                soc_rdata = sram_rdata;
            end
            if (rd_owner_acc) begin
                acc_rdata = sram_rdata;
            end
        end
    end

endmodule
